modulation_sampler: RTL

Modulation read sequencer on the `CLK` domain that consumes the modulation BRAM read port (`MOD_BUS`: `IDX`, `SEGMENT`, `VALUE`). On each `UPDATE` strobe it samples one 8-bit modulation value and delivers it with a one-cycle valid pulse to the intensity/PWE path. It also maintains the per-segment frequency divider and sample index, and performs immediate or loop-boundary segment swaps.

---
 rtl/modulation_sampler_if.sv | 12 +
 rtl/modulation_sampler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/modulation_sampler_if.sv
// Modulation BRAM read port: the sequencer drives the address (master),
// the BRAM returns the byte READ_LATENCY cycles later (slave).
interface modulation_sampler_if #(
  parameter int IDX_W = 15
);
  logic [IDX_W-1:0] IDX;
  logic             SEGMENT;
  logic [7:0]       VALUE;

  modport master (output IDX, output SEGMENT, input VALUE);
  modport slave  (input IDX, input SEGMENT, output VALUE);
endinterface

// File: rtl/modulation_sampler.sv
// Modulation read sequencer: one BRAM read per accepted UPDATE, with a per-segment
// frequency divider, wrapping sample index and immediate/loop-boundary segment swaps.
module modulation_sampler #(
  parameter int IDX_W        = 15,
  parameter int READ_LATENCY = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UPDATE,
  input  logic [15:0]      FREQ_DIV_0,
  input  logic [15:0]      FREQ_DIV_1,
  input  logic [IDX_W-1:0] CYCLE_0,
  input  logic [IDX_W-1:0] CYCLE_1,
  input  logic             REQ_VALID,
  input  logic             REQ_SEGMENT,
  input  logic             REQ_IMMEDIATE,
  modulation_sampler_if.master MOD_BUS,
  output logic [7:0]       VALUE,
  output logic             VALID,
  output logic             CUR_SEGMENT,
  output logic             BUSY,
  output logic             OVERRUN
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_e;

  localparam int WCNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(READ_LATENCY - 1);

  // Divider terminal count D-1, with a programmed 0 behaving as 1.
  function automatic logic [15:0] div_last(input logic [15:0] fd);
    return (fd == 16'd0) ? 16'd0 : fd - 16'd1;
  endfunction

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              seg_q, seg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       div_cnt_q, div_cnt_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_seg_q, pend_seg_d;
  logic              pend_imm_q, pend_imm_d;
  logic [IDX_W-1:0]  mod_idx_q, mod_idx_d;
  logic              mod_seg_q, mod_seg_d;
  logic [7:0]        value_q, value_d;
  logic              valid_q, valid_d;
  logic              cur_seg_q, cur_seg_d;
  logic              overrun_q, overrun_d;

  logic              base_seg;
  logic [IDX_W-1:0]  base_idx;
  logic [15:0]       base_div;
  logic              base_pend;
  logic [15:0]       sel_fd;
  logic [IDX_W-1:0]  sel_cyc;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    seg_d        = seg_q;
    idx_d        = idx_q;
    div_cnt_d    = div_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_seg_d   = pend_seg_q;
    pend_imm_d   = pend_imm_q;
    mod_idx_d    = mod_idx_q;
    mod_seg_d    = mod_seg_q;
    value_d      = value_q;
    valid_d      = 1'b0;
    cur_seg_d    = cur_seg_q;
    overrun_d    = overrun_q;

    // An immediate request rebases the read to (pend_seg, 0) with a fresh divider.
    base_seg  = seg_q;
    base_idx  = idx_q;
    base_div  = div_cnt_q;
    base_pend = pend_valid_q;
    if (pend_valid_q && pend_imm_q) begin
      base_seg  = pend_seg_q;
      base_idx  = '0;
      base_div  = '0;
      base_pend = 1'b0;
    end
    sel_fd  = base_seg ? FREQ_DIV_1 : FREQ_DIV_0;
    sel_cyc = base_seg ? CYCLE_1 : CYCLE_0;

    unique case (state_q)
      S_IDLE: begin
        if (UPDATE) begin
          state_d      = S_WAIT;
          wait_cnt_d   = '0;
          mod_idx_d    = base_idx;
          mod_seg_d    = base_seg;
          cur_seg_d    = base_seg;
          seg_d        = base_seg;
          pend_valid_d = base_pend;
          // >= keeps a lowered divider from stalling until the counter rolls over.
          if (base_div >= div_last(sel_fd)) begin
            div_cnt_d = '0;
            if (base_idx >= sel_cyc) begin
              idx_d = '0;
              if (base_pend) begin
                seg_d        = pend_seg_q;
                pend_valid_d = 1'b0;
              end
            end else begin
              idx_d = base_idx + 1'b1;
            end
          end else begin
            div_cnt_d = base_div + 16'd1;
            idx_d     = base_idx;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_CAPTURE;
        else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_CAPTURE: begin
        value_d = MOD_BUS.VALUE;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (UPDATE && (state_q != S_IDLE)) overrun_d = 1'b1;

    // A request arriving alongside an UPDATE lands after that UPDATE's read.
    if (REQ_VALID && !((REQ_SEGMENT == seg_q) && !pend_valid_q)) begin
      pend_valid_d = 1'b1;
      pend_seg_d   = REQ_SEGMENT;
      pend_imm_d   = REQ_IMMEDIATE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      seg_q        <= 1'b0;
      idx_q        <= '0;
      div_cnt_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_seg_q   <= 1'b0;
      pend_imm_q   <= 1'b0;
      mod_idx_q    <= '0;
      mod_seg_q    <= 1'b0;
      value_q      <= '0;
      valid_q      <= 1'b0;
      cur_seg_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      seg_q        <= seg_d;
      idx_q        <= idx_d;
      div_cnt_q    <= div_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_seg_q   <= pend_seg_d;
      pend_imm_q   <= pend_imm_d;
      mod_idx_q    <= mod_idx_d;
      mod_seg_q    <= mod_seg_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      cur_seg_q    <= cur_seg_d;
      overrun_q    <= overrun_d;
    end
  end

  assign MOD_BUS.IDX     = mod_idx_q;
  assign MOD_BUS.SEGMENT = mod_seg_q;
  assign VALUE           = value_q;
  assign VALID           = valid_q;
  assign CUR_SEGMENT     = cur_seg_q;
  assign BUSY            = (state_q != S_IDLE);
  assign OVERRUN         = overrun_q;

endmodule
